// File: rtl/muldiv_iter_unit_pkg.sv
// Shared constants and state encoding for the iterative RV32M/RV64M multiply/divide unit.
package muldiv_iter_unit_pkg;

    localparam logic [2:0] MUL_F3    = 3'b000;
    localparam logic [2:0] MULH_F3   = 3'b001;
    localparam logic [2:0] MULHSU_F3 = 3'b010;
    localparam logic [2:0] MULHU_F3  = 3'b011;
    localparam logic [2:0] DIV_F3    = 3'b100;
    localparam logic [2:0] DIVU_F3   = 3'b101;
    localparam logic [2:0] REM_F3    = 3'b110;
    localparam logic [2:0] REMU_F3   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Special-case results are uniform bit fills, replicated to XLEN at the use site.
    localparam logic DIV_ZERO_QUOT_BIT = 1'b1;
    localparam logic OVF_REM_BIT       = 1'b0;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module muldiv_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] fixed
);

    assign fixed = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_iter_unit.sv
// Multi-cycle M-extension unit: radix-2 shift-add multiplier and restoring divider, XLEN iterations.
module muldiv_iter_unit
    import muldiv_iter_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              neg1_q, neg1_d, neg2_q, neg2_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              src1_signed, src2_signed, in_neg1, in_neg2;
    logic [XLEN-1:0]   src1_abs, src2_abs;
    logic              div_zero, div_ovf;

    assign src1_signed = (funct3 == MULH_F3) || (funct3 == MULHSU_F3) ||
                         (funct3 == DIV_F3) || (funct3 == REM_F3);
    assign src2_signed = (funct3 == MULH_F3) || (funct3 == DIV_F3) || (funct3 == REM_F3);
    assign in_neg1     = src1_signed && src1[XLEN-1];
    assign in_neg2     = src2_signed && src2[XLEN-1];
    assign div_zero    = (src2 == '0);
    assign div_ovf     = ((funct3 == DIV_F3) || (funct3 == REM_F3)) &&
                         (src1 == MIN_INT) && (src2 == '1);

    muldiv_sign_fix #(.WIDTH(XLEN)) u_abs1 (.value(src1), .negate(in_neg1), .fixed(src1_abs));
    muldiv_sign_fix #(.WIDTH(XLEN)) u_abs2 (.value(src2), .negate(in_neg2), .fixed(src2_abs));

    // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
    logic [XLEN:0]     mul_sum, rem_shift, rem_diff;
    logic              borrow;
    logic [2*XLEN-1:0] mul_next, div_next, step;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign rem_diff  = rem_shift - {1'b0, opnd_q};
    assign borrow    = rem_diff[XLEN];
    assign div_next  = {(borrow ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0]),
                        acc_q[XLEN-2:0], ~borrow};
    assign step      = op_q[2] ? div_next : mul_next;

    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   div_sel, div_fixed, fix_result;
    logic              div_neg;

    assign div_sel = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    // Remainder follows the dividend's sign; quotient is negative when signs differ.
    assign div_neg = op_q[1] ? neg1_q : (neg1_q ^ neg2_q);

    muldiv_sign_fix #(.WIDTH(2*XLEN)) u_prod_fix (
        .value (step),
        .negate(neg1_q ^ neg2_q),
        .fixed (prod_fixed)
    );
    muldiv_sign_fix #(.WIDTH(XLEN)) u_div_fix (
        .value (div_sel),
        .negate(div_neg),
        .fixed (div_fixed)
    );

    assign fix_result = op_q[2]            ? div_fixed :
                        (op_q == MUL_F3)   ? prod_fixed[XLEN-1:0] :
                                             prod_fixed[2*XLEN-1:XLEN];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    op_d   = funct3;
                    neg1_d = in_neg1;
                    neg2_d = in_neg2;
                    cnt_d  = '0;
                    if (funct3[2]) begin
                        opnd_d = src2_abs;
                        acc_d  = {{XLEN{1'b0}}, src1_abs};
                    end else begin
                        opnd_d = src1_abs;
                        acc_d  = {{XLEN{1'b0}}, src2_abs};
                    end
                    if (funct3[2] && div_zero) begin
                        result_d = funct3[1] ? src1 : {XLEN{DIV_ZERO_QUOT_BIT}};
                        state_d  = DONE;
                    end else if (div_ovf) begin
                        result_d = funct3[1] ? {XLEN{OVF_REM_BIT}} : src1;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        result_d = fix_result;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Scoreboard bench for muldiv_iter_unit at XLEN=32: directed M-ext cases, flush, reset, random ops.
module tb_muldiv_iter_unit;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src1, src2, result;

    always #5 clk = ~clk;

    muldiv_iter_unit #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .funct3   (funct3),
        .src1     (src1),
        .src2     (src2),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_result;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ae, be, prod;
        int          sa, sb;
        sa = a;
        sb = b;
        ae = {{32{(f3 == 3'b001 || f3 == 3'b010) ? a[31] : 1'b0}}, a};
        be = {{32{(f3 == 3'b001) ? b[31] : 1'b0}}, b};
        prod = ae * be;
        case (f3)
            3'b000: return prod[31:0];
            3'b001, 3'b010, 3'b011: return prod[63:32];
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        int          edges;
        int          exp_lat;
        logic [31:0] exp;
        bit          special;
        exp     = ref_model(f3, a, b);
        special = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        exp_lat = special ? 1 : XLEN + 1;
        @(negedge clk);
        funct3   = f3;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        // Scramble the inputs to show they are only sampled at acceptance.
        in_valid = 1'b0;
        funct3   = 3'($urandom);
        src1     = $urandom;
        src2     = $urandom;
        edges    = 1;
        while (!out_valid && edges < XLEN + 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check_eq($sformatf("latency f3=%0d", f3), 64'(edges), 64'(exp_lat));
        if (!out_valid) begin
            void'(exp_q.pop_front());
            return;
        end
        check_eq("in_ready_in_done", 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_result", 64'(result), 64'(exp));
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
        end
        check_eq($sformatf("result f3=%0d a=%0h b=%0h", f3, a, b), 64'(result),
                 64'(exp_q.pop_front()));
        last_result = result;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("idle_after_ack", 64'({out_valid, in_ready, busy}), 64'(3'b010));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        funct3    = '0;
        src1      = '0;
        src2      = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_flags", 64'({in_ready, out_valid, busy}), 64'(3'b100));
        check_eq("reset_result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'b101, 32'd100, 32'd7, 0);
        run_op(3'b111, 32'd100, 32'd7, 0);
        run_op(3'b100, 32'd5, 32'd0, 0);
        run_op(3'b111, 32'd5, 32'd0, 0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'b101, 32'd100, 32'd7, 5);

        // Flush mid-calculation at counter 10.
        @(negedge clk);
        funct3   = 3'b101;
        src1     = 32'd1000;
        src2     = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_idle", 64'({out_valid, in_ready, busy}), 64'(3'b010));
        check_eq("flush_result_kept", 64'(result), 64'(last_result));
        repeat (3) @(posedge clk);
        #1;
        check_eq("flush_no_valid", 64'(out_valid), 64'd0);
        run_op(3'b110, 32'hFFFF_FF9C, 32'd7, 0);

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        funct3   = 3'b000;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check_eq("flush_idle_no_accept", 64'(busy), 64'd0);

        // Async reset between edges mid-CALC.
        @(negedge clk);
        funct3   = 3'b000;
        src1     = 32'd12345;
        src2     = 32'd678;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_reset_flags", 64'({in_ready, out_valid, busy}), 64'(3'b100));
        check_eq("async_reset_result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(3'b000, 32'd12345, 32'd678, 0);

        for (int n = 0; n < 300; n++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op(f3, a, b, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
